// File: rtl/mem_bus_arbiter_if.sv
// Fetch, data and downstream memory port signals of the memory bus arbiter.
interface mem_bus_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) ();
   localparam int unsigned MASK_W = DATA_WIDTH / 8;

   logic                  i_req_valid;
   logic                  i_req_ready;
   logic [ADDR_WIDTH-1:0] i_req_addr;
   logic                  i_resp_valid;
   logic [DATA_WIDTH-1:0] i_resp_rdata;
   logic                  i_resp_error;

   logic                  d_req_valid;
   logic                  d_req_ready;
   logic [ADDR_WIDTH-1:0] d_req_addr;
   logic                  d_req_wen;
   logic [DATA_WIDTH-1:0] d_req_wdata;
   logic [MASK_W-1:0]     d_req_wmask;
   logic                  d_resp_valid;
   logic [DATA_WIDTH-1:0] d_resp_rdata;
   logic                  d_resp_error;

   logic                  m_req_valid;
   logic                  m_req_ready;
   logic [ADDR_WIDTH-1:0] m_req_addr;
   logic                  m_req_wen;
   logic [DATA_WIDTH-1:0] m_req_wdata;
   logic [MASK_W-1:0]     m_req_wmask;
   logic [2:0]            m_req_target;
   logic                  m_resp_valid;
   logic [DATA_WIDTH-1:0] m_resp_rdata;

   // Arbiter view: serves the two requesters and masters the downstream port.
   modport master (
      input  i_req_valid, i_req_addr,
      output i_req_ready, i_resp_valid, i_resp_rdata, i_resp_error,
      input  d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_wmask,
      output d_req_ready, d_resp_valid, d_resp_rdata, d_resp_error,
      output m_req_valid, m_req_addr, m_req_wen, m_req_wdata, m_req_wmask, m_req_target,
      input  m_req_ready, m_resp_valid, m_resp_rdata
   );

   // Environment view: requesters plus the downstream interconnect.
   modport slave (
      output i_req_valid, i_req_addr,
      input  i_req_ready, i_resp_valid, i_resp_rdata, i_resp_error,
      output d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_wmask,
      input  d_req_ready, d_resp_valid, d_resp_rdata, d_resp_error,
      input  m_req_valid, m_req_addr, m_req_wen, m_req_wdata, m_req_wmask, m_req_target,
      output m_req_ready, m_resp_valid, m_resp_rdata
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one downstream memory/MMIO port between fetch and
// data requesters, one transaction in flight, with target decode and timeout.
module mem_bus_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_bus_arbiter_if.master bus
);
   localparam int unsigned MASK_W = DATA_WIDTH / 8;
   localparam int unsigned CNT_W  = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   localparam logic [2:0] TGT_MEM     = 3'd0;
   localparam logic [2:0] TGT_CLINT   = 3'd1;
   localparam logic [2:0] TGT_EDISK   = 3'd2;
   localparam logic [2:0] TGT_UART_TX = 3'd3;
   localparam logic [2:0] TGT_UART_RX = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t             state;
   logic               last_d;   // 1: data was granted last, 0: fetch
   logic               cur_d;    // transaction in flight belongs to data side
   logic [CNT_W-1:0]   cnt;

   logic                  pick_d_c, pick_i_c, idle_c;
   logic [ADDR_WIDTH-1:0] sel_addr_c;
   logic [2:0]            sel_tgt_c;
   logic                  timeout_c, done_c, done_err_c;
   logic [DATA_WIDTH-1:0] done_rdata_c;

   function automatic logic [2:0] decode(input logic [ADDR_WIDTH-1:0] a);
      if (a >= ADDR_WIDTH'(32'hF000_0000) && a < ADDR_WIDTH'(32'hF000_0010))      return TGT_CLINT;
      else if (a >= ADDR_WIDTH'(32'hF800_0000) && a < ADDR_WIDTH'(32'hF800_0018)) return TGT_EDISK;
      else if (a == ADDR_WIDTH'(32'hFF00_0000))                                   return TGT_UART_TX;
      else if (a >= ADDR_WIDTH'(32'hFF00_0010) && a < ADDR_WIDTH'(32'hFF00_0020)) return TGT_UART_RX;
      else                                                                        return TGT_MEM;
   endfunction

   // Grant selection: lone requester wins, ties go to the side not granted last.
   always_comb begin
      idle_c     = (state == S_IDLE);
      pick_d_c   = bus.d_req_valid && (!bus.i_req_valid || !last_d);
      pick_i_c   = bus.i_req_valid && !pick_d_c;
      sel_addr_c = pick_d_c ? bus.d_req_addr : bus.i_req_addr;
      sel_tgt_c  = decode(sel_addr_c);
   end

   assign bus.d_req_ready = rst_n && idle_c && pick_d_c;
   assign bus.i_req_ready = rst_n && idle_c && pick_i_c;

   // Completion of the in-flight access: downstream response or forced timeout.
   always_comb begin
      done_c       = 1'b0;
      done_err_c   = 1'b0;
      done_rdata_c = '0;
      timeout_c    = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
      case (state)
         S_ISSUE: begin
            if (timeout_c) begin
               done_c     = 1'b1;
               done_err_c = 1'b1;
            end
         end
         S_WAIT: begin
            if (bus.m_resp_valid) begin
               done_c       = 1'b1;
               done_rdata_c = bus.m_req_wen ? '0 : bus.m_resp_rdata;
            end else if (timeout_c) begin
               done_c     = 1'b1;
               done_err_c = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Transaction FSM with registered downstream request and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         last_d           <= 1'b0;
         cur_d            <= 1'b0;
         cnt              <= '0;
         bus.m_req_valid  <= 1'b0;
         bus.m_req_addr   <= '0;
         bus.m_req_wen    <= 1'b0;
         bus.m_req_wdata  <= '0;
         bus.m_req_wmask  <= '0;
         bus.m_req_target <= TGT_MEM;
         bus.i_resp_valid <= 1'b0;
         bus.i_resp_rdata <= '0;
         bus.i_resp_error <= 1'b0;
         bus.d_resp_valid <= 1'b0;
         bus.d_resp_rdata <= '0;
         bus.d_resp_error <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_d_c || pick_i_c) begin
                  last_d <= pick_d_c;
                  cur_d  <= pick_d_c;
                  cnt    <= '0;
                  if (pick_i_c && sel_tgt_c != TGT_MEM) begin
                     // Fetch from a device region faults without touching the bus.
                     state            <= S_RESP;
                     bus.i_resp_valid <= 1'b1;
                     bus.i_resp_error <= 1'b1;
                     bus.i_resp_rdata <= '0;
                  end else begin
                     state            <= S_ISSUE;
                     bus.m_req_valid  <= 1'b1;
                     bus.m_req_addr   <= sel_addr_c;
                     bus.m_req_wen    <= pick_d_c && bus.d_req_wen;
                     bus.m_req_wdata  <= pick_d_c ? bus.d_req_wdata : '0;
                     bus.m_req_wmask  <= pick_d_c ? bus.d_req_wmask : MASK_W'(0);
                     bus.m_req_target <= sel_tgt_c;
                  end
               end
            end
            S_ISSUE, S_WAIT: begin
               cnt <= cnt + CNT_W'(1);
               if (done_c) begin
                  state           <= S_RESP;
                  bus.m_req_valid <= 1'b0;
                  if (cur_d) begin
                     bus.d_resp_valid <= 1'b1;
                     bus.d_resp_error <= done_err_c;
                     bus.d_resp_rdata <= done_rdata_c;
                  end else begin
                     bus.i_resp_valid <= 1'b1;
                     bus.i_resp_error <= done_err_c;
                     bus.i_resp_rdata <= done_rdata_c;
                  end
               end else if (state == S_ISSUE && bus.m_req_ready) begin
                  state           <= S_WAIT;
                  bus.m_req_valid <= 1'b0;
               end
            end
            S_RESP: begin
               state            <= S_IDLE;
               bus.i_resp_valid <= 1'b0;
               bus.i_resp_error <= 1'b0;
               bus.i_resp_rdata <= '0;
               bus.d_resp_valid <= 1'b0;
               bus.d_resp_error <= 1'b0;
               bus.d_resp_rdata <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
